// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming KxK convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int K_DEFAULT  = 5;
    localparam int KK_DEFAULT = K_DEFAULT * K_DEFAULT;

    function automatic int out_w(input int img_w, input int k);
        return img_w - k + 1;
    endfunction

    function automatic int out_h(input int img_h, input int k);
        return img_h - k + 1;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 chained IMG_W-deep pixel shift lines; column[K-1] is the live pixel, column[0] the oldest line.
// Combinational column out, one shift per enabled cycle; a low enable freezes every line.
module conv_line_buffer #(
    parameter int IMG_W = 28,
    parameter int DW    = 8,
    parameter int K     = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [DW-1:0]         din,
    output logic [K-1:0][DW-1:0]  column
);

    // Element 0 is the newest pixel of a line, element IMG_W-1 the one leaving it.
    logic [K-2:0][IMG_W-1:0][DW-1:0] lines;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lines <= '0;
        end else if (en) begin
            lines[0] <= {lines[0][IMG_W-2:0], din};
            for (int l = 1; l < K-1; l++) begin
                lines[l] <= {lines[l][IMG_W-2:0], lines[l-1][IMG_W-1]};
            end
        end
    end

    always_comb begin
        column = '0;
        column[K-1] = din;
        for (int l = 0; l < K-1; l++) begin
            column[K-2-l] = lines[l][IMG_W-1];
        end
    end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution over a raster pixel stream with a serially loaded signed kernel.
// Results 2 cycles after the completing pixel; no backpressure, din_valid gaps freeze the datapath.
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = K_DEFAULT,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int OW    = 32,
    parameter int RELU  = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      weight_en,
    input  logic [WW-1:0]             weight,
    output logic                      wt_ready,
    input  logic                      din_valid,
    input  logic [DW-1:0]             din,
    output logic                      busy,
    output logic [OW-1:0]             dout,
    output logic                      ovalid,
    output logic                      done,
    output logic [idx_w(IMG_H)-1:0]   out_row,
    output logic [idx_w(IMG_W)-1:0]   out_col
);

    localparam int KK  = K * K;
    localparam int WCW = idx_w(KK);
    localparam int RW  = idx_w(IMG_H);
    localparam int CW  = idx_w(IMG_W);
    localparam int PW  = DW + WW + 1;

    generate
        if (OW < DW + WW + $clog2(K * K) + 1) begin : g_ow_too_narrow
            $error("conv_kxk_stream: OW too narrow for an exact KxK sum");
        end
        if (K < 3 || K > 7 || (K % 2) == 0 || out_w(IMG_W, K) < 1 || out_h(IMG_H, K) < 1) begin : g_bad_k
            $error("conv_kxk_stream: K must be odd, 3..7, and fit the image");
        end
    endgenerate

    state_t state, state_nxt;
    logic   accept, start_ok, last_px;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          v0, last0, v1, last1;
    logic [RW-1:0] r0, r1;
    logic [CW-1:0] c0, c1;

    assign accept   = (state == RUN) && din_valid;
    assign start_ok = (state == IDLE) && start && wt_ready;
    assign last_px  = accept && (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (last_px)  state_nxt = DRAIN;
            DRAIN:   if (last1)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Kernel load; a write after a complete load restarts the kernel at index 0.
    logic signed [WW-1:0] kern [KK];
    logic [WCW-1:0]       wcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < KK; k++) kern[k] <= '0;
            wcnt     <= '0;
            wt_ready <= 1'b0;
        end else if (state == IDLE && weight_en && !start_ok) begin
            if (wt_ready) begin
                kern[0]  <= weight;
                wcnt     <= WCW'(1);
                wt_ready <= 1'b0;
            end else begin
                kern[wcnt] <= weight;
                if (wcnt == WCW'(KK - 1)) begin
                    wcnt     <= '0;
                    wt_ready <= 1'b1;
                end else begin
                    wcnt <= wcnt + WCW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
        end else if (start_ok) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    logic [K-1:0][DW-1:0] column;

    conv_line_buffer #(.IMG_W(IMG_W), .DW(DW), .K(K)) u_lines (
        .clk    (clk),
        .rstn   (rstn),
        .en     (accept),
        .din    (din),
        .column (column)
    );

    // win[i][K-1] holds the newest column; row i pairs with kernel row i.
    logic [DW-1:0] win [K][K];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win[i][j] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K-1; j++) win[i][j] <= win[i][j+1];
                win[i][K-1] <= column[i];
            end
        end
    end

    logic signed [PW-1:0] prod [KK];
    logic [OW-1:0]        acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < KK; k++) begin
            acc = acc + {{(OW - PW){prod[k][PW-1]}}, prod[k]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v0 <= 1'b0;  last0 <= 1'b0;  r0 <= '0;  c0 <= '0;
            v1 <= 1'b0;  last1 <= 1'b0;  r1 <= '0;  c1 <= '0;
            for (int k = 0; k < KK; k++) prod[k] <= '0;
            ovalid  <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            v0    <= accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
            last0 <= last_px;
            r0    <= row - RW'(K - 1);
            c0    <= col - CW'(K - 1);
            v1    <= v0;
            last1 <= last0;
            r1    <= r0;
            c1    <= c0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    prod[i*K+j] <= PW'($signed({1'b0, win[i][j]})) * PW'(kern[i*K+j]);
            ovalid  <= v1;
            done    <= last1;
            out_row <= r1;
            out_col <= c1;
            dout    <= (RELU != 0 && acc[OW-1]) ? '0 : acc;
        end
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Drives frames into a plain and a ReLU instance and scores every result against an arithmetic model.
module tb_conv_kxk_stream;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int K    = 5;
    localparam int KK   = 25;
    localparam int NOUT = 576;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, weight_en, din_valid;
    logic [7:0] weight, din;
    logic       wt_ready, busy, ovalid, done;
    logic [31:0] dout;
    logic [4:0] out_row, out_col;
    logic       wt_ready_r, busy_r, ovalid_r, done_r;
    logic [31:0] dout_r;
    logic [4:0] out_row_r, out_col_r;

    conv_kxk_stream dut (
        .clk(clk), .rstn(rstn), .start(start), .weight_en(weight_en), .weight(weight),
        .wt_ready(wt_ready), .din_valid(din_valid), .din(din), .busy(busy), .dout(dout),
        .ovalid(ovalid), .done(done), .out_row(out_row), .out_col(out_col)
    );

    conv_kxk_stream #(.RELU(1)) dut_r (
        .clk(clk), .rstn(rstn), .start(start), .weight_en(weight_en), .weight(weight),
        .wt_ready(wt_ready_r), .din_valid(din_valid), .din(din), .busy(busy_r), .dout(dout_r),
        .ovalid(ovalid_r), .done(done_r), .out_row(out_row_r), .out_col(out_col_r)
    );

    typedef struct {
        logic [31:0] d;
        logic [31:0] dr;
        int          row;
        int          col;
        int          cyc;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   img [H][W];
    int   kern [KK];
    int   cyc = 0;
    int   out_cnt = 0;
    int   done_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Direct definition of the convolution at input pixel (r,c).
    function automatic exp_t model(input int r, input int c);
        exp_t e;
        int   s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += kern[i*K+j] * img[r-K+1+i][c-K+1+j];
        e.d    = s;
        e.dr   = (s < 0) ? 0 : s;
        e.row  = r - K + 1;
        e.col  = c - K + 1;
        e.last = (r == H-1) && (c == W-1);
        e.cyc  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            check("relu_twin_ctl", {ovalid_r, done_r, busy_r, wt_ready_r, out_row_r, out_col_r},
                                   {ovalid, done, busy, wt_ready, out_row, out_col});
            if (ovalid) begin
                if (exp_q.size() == 0) begin
                    check("extra_ovalid", ovalid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("dout", dout, mon_e.d);
                    check("dout_relu", dout_r, mon_e.dr);
                    check("out_row", out_row, mon_e.row);
                    check("out_col", out_col, mon_e.col);
                    check("latency", cyc, mon_e.cyc);
                    check("done", done, mon_e.last);
                    out_cnt++;
                end
            end else begin
                check("done_alone", done, 1'b0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic load(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            weight_en = 1'b1;
            weight    = 8'(kern[i]);
            @(posedge clk); #1;
        end
        weight_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {dout, ovalid, done, busy, wt_ready, out_row, out_col}, 64'd0);
    endtask

    // pm: 0 all ones, 1 (r*W+c)&255, 2 column index, 3 random. stop_after<0 runs the whole frame.
    task automatic run_frame(input int pm, input int gap_pct, input bit inject, input int stop_after);
        int   n = 0;
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (pm == 0) ? 1 : (pm == 1) ? ((r*W + c) & 255) :
                            (pm == 2) ? c : int'($urandom_range(0, 255));
        out_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (n == stop_after) return;
                while (int'($urandom_range(0, 99)) < gap_pct) begin
                    din_valid = 1'b0;
                    din       = 8'($urandom);
                    if (inject) begin
                        start     = 1'($urandom_range(0, 1));
                        weight_en = 1'($urandom_range(0, 1));
                        weight    = 8'($urandom);
                    end
                    @(posedge clk); #1;
                end
                start     = 1'b0;
                weight_en = 1'b0;
                din_valid = 1'b1;
                din       = 8'(img[r][c]);
                @(posedge clk); #1;
                n++;
                if (r >= K-1 && c >= K-1) begin
                    e     = model(r, c);
                    e.cyc = cyc + 2;
                    exp_q.push_back(e);
                end
            end
        end
        din = 8'hff;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int k = 0; k < 40 && busy; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check("frame_idle", busy, 1'b0);
        check("frame_outputs", out_cnt, NOUT);
        check("frame_done", done_cnt, 1);
        check("frame_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; weight_en = 1'b0; weight = '0; din_valid = 1'b0; din = '0;
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1;
        rstn = 1'b1;

        foreach (kern[i]) kern[i] = 2;
        load(0, 23);
        check("wt_ready_partial", wt_ready, 1'b0);
        pulse_start();
        check("start_without_kernel", busy, 1'b0);
        load(24, 24);
        check("wt_ready_full", wt_ready, 1'b1);
        run_frame(0, 0, 1'b0, -1);

        foreach (kern[i]) kern[i] = 0;
        kern[12] = 1;
        load(0, 24);
        run_frame(1, 0, 1'b0, -1);

        foreach (kern[i]) kern[i] = 1;
        load(0, 24);
        run_frame(2, 0, 1'b0, -1);

        foreach (kern[i]) kern[i] = -2;
        load(0, 24);
        run_frame(0, 0, 1'b0, -1);

        foreach (kern[i]) kern[i] = int'($urandom_range(0, 255)) - 128;
        load(0, 24);
        run_frame(3, 50, 1'b1, -1);
        check("wt_ready_kept", wt_ready, 1'b1);
        run_frame(3, 50, 1'b0, -1);

        foreach (kern[i]) kern[i] = int'($urandom_range(0, 255)) - 128;
        load(0, 2);
        check("reload_drops_ready", wt_ready, 1'b0);
        pulse_start();
        check("start_during_reload", busy, 1'b0);
        load(3, 24);
        check("reload_ready", wt_ready, 1'b1);
        run_frame(3, 30, 1'b0, -1);

        run_frame(3, 0, 1'b0, 300);
        rstn      = 1'b0;
        din_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_zero("mid_frame_reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt, 0);
        check("idle_after_reset", {busy, wt_ready}, 2'b00);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
